// File: rtl/prog_packet_writer.sv
// prog_packet_writer: parses SYNC/ADR/LEN/DATA/CHK packets from a UART byte
// stream and programs an external memory through a setup/pulse/hold write
// sequencer with a one-byte holding buffer.
module prog_packet_writer #(
    parameter int unsigned WR_CYCLES = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [20:0] adr,
    output logic [7:0]  data,
    output logic        write,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, ADR2, ADR1, ADR0, LEN, DATA, CHK} pstate_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wstate_t;

    pstate_t     pstate_r;
    wstate_t     wstate_r;
    logic [3:0]  pulse_cnt_r;
    logic [20:0] addr_r;       // address of the next DATA byte
    logic [4:0]  adr_hi_r;
    logic [7:0]  adr_mid_r;
    logic [8:0]  cnt_r;        // DATA bytes still expected (1..256)
    logic [7:0]  sum_r;
    logic        buf_full_r;
    logic [7:0]  buf_data_r;
    logic [20:0] buf_adr_r;    // buffered byte keeps its own address
    logic        done_pend_r;

    logic [7:0]  sum_s;
    logic        pending_s;
    logic        can_issue_s;

    // Checksum including the byte presented this cycle
    assign sum_s = sum_r + rx_data;

    // Writes still outstanding in the sequencer or the holding buffer
    assign pending_s = (wstate_r != W_IDLE) || buf_full_r;

    // A new byte can go straight to W_SETUP when the sequencer is idle or is
    // finishing its hold with nothing buffered behind it
    assign can_issue_s = (wstate_r == W_IDLE) || ((wstate_r == W_HOLD) && !buf_full_r);

    // busy is a pure function of state flops, never of rx_data/rx_valid
    assign busy = (pstate_r != IDLE) || (wstate_r != W_IDLE) || buf_full_r;

    // Parser, write sequencer, holding buffer and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_r    <= IDLE;
            wstate_r    <= W_IDLE;
            pulse_cnt_r <= 4'd0;
            addr_r      <= 21'd0;
            adr_hi_r    <= 5'd0;
            adr_mid_r   <= 8'd0;
            cnt_r       <= 9'd0;
            sum_r       <= 8'd0;
            buf_full_r  <= 1'b0;
            buf_data_r  <= 8'd0;
            buf_adr_r   <= 21'd0;
            done_pend_r <= 1'b0;
            adr         <= 21'd0;
            data        <= 8'd0;
            write       <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;

            // write sequencer
            case (wstate_r)
                W_IDLE: begin
                    wstate_r <= W_IDLE;
                end
                W_SETUP: begin
                    write       <= 1'b1;
                    pulse_cnt_r <= 4'(WR_CYCLES - 1);
                    wstate_r    <= W_PULSE;
                end
                W_PULSE: begin
                    if (pulse_cnt_r == 4'd0) begin
                        write    <= 1'b0;
                        wstate_r <= W_HOLD;
                    end else begin
                        pulse_cnt_r <= pulse_cnt_r - 4'd1;
                    end
                end
                W_HOLD: begin
                    if (buf_full_r) begin
                        adr        <= buf_adr_r;
                        data       <= buf_data_r;
                        buf_full_r <= 1'b0;
                        wstate_r   <= W_SETUP;
                    end else begin
                        wstate_r <= W_IDLE;
                    end
                end
                default: begin
                    write    <= 1'b0;
                    wstate_r <= W_IDLE;
                end
            endcase

            // deferred done once every write of a good packet has finished
            if (done_pend_r && !pending_s) begin
                done        <= 1'b1;
                done_pend_r <= 1'b0;
            end

            // packet parser, one state per accepted byte
            if (rx_valid) begin
                case (pstate_r)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            error    <= 1'b0;
                            sum_r    <= 8'd0;
                            pstate_r <= ADR2;
                        end
                    end
                    ADR2: begin
                        if (rx_data[7:5] != 3'd0) begin
                            error    <= 1'b1;
                            pstate_r <= IDLE;
                        end else begin
                            adr_hi_r <= rx_data[4:0];
                            sum_r    <= sum_s;
                            pstate_r <= ADR1;
                        end
                    end
                    ADR1: begin
                        adr_mid_r <= rx_data;
                        sum_r     <= sum_s;
                        pstate_r  <= ADR0;
                    end
                    ADR0: begin
                        addr_r   <= {adr_hi_r, adr_mid_r, rx_data};
                        sum_r    <= sum_s;
                        pstate_r <= LEN;
                    end
                    LEN: begin
                        cnt_r    <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        sum_r    <= sum_s;
                        pstate_r <= DATA;
                    end
                    DATA: begin
                        if (can_issue_s || !buf_full_r) begin
                            if (can_issue_s) begin
                                adr      <= addr_r;
                                data     <= rx_data;
                                wstate_r <= W_SETUP;
                            end else begin
                                buf_full_r <= 1'b1;
                                buf_data_r <= rx_data;
                                buf_adr_r  <= addr_r;
                            end
                            addr_r <= addr_r + 21'd1;
                            sum_r  <= sum_s;
                            cnt_r  <= cnt_r - 9'd1;
                            if (cnt_r == 9'd1) begin
                                pstate_r <= CHK;
                            end
                        end else begin
                            // overrun: drop the byte, let queued writes drain
                            error    <= 1'b1;
                            pstate_r <= IDLE;
                        end
                    end
                    CHK: begin
                        if (sum_s == 8'h00) begin
                            if (pending_s) begin
                                done_pend_r <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end else begin
                            error <= 1'b1;
                        end
                        pstate_r <= IDLE;
                    end
                    default: begin
                        pstate_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_packet_writer.sv
// Directed bench for prog_packet_writer: packet writes, checksum outcomes,
// address wrap, buffer overrun, bad address and reset during a write pulse.
module tb_prog_packet_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [20:0] adr;
    logic [7:0]  data;
    logic        write;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    // write/done monitor state
    logic [20:0] log_adr  [0:63];
    logic [7:0]  log_data [0:63];
    int          log_len  [0:63];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          stab_bad = 0;
    int          cur_len  = 0;
    logic        prev_w   = 1'b0;

    prog_packet_writer #(.WR_CYCLES(4), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .adr      (adr),
        .data     (data),
        .write    (write),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Log every write pulse (address, data, width) and every done cycle
    always @(negedge clk) begin
        if (write === 1'b1 && prev_w !== 1'b1) begin
            log_adr[wr_cnt % 64]  <= adr;
            log_data[wr_cnt % 64] <= data;
            wr_cnt  <= wr_cnt + 1;
            cur_len <= 1;
        end else if (write === 1'b1) begin
            cur_len <= cur_len + 1;
            if (adr !== log_adr[(wr_cnt - 1) % 64] || data !== log_data[(wr_cnt - 1) % 64])
                stab_bad <= stab_bad + 1;
        end else if (prev_w === 1'b1) begin
            log_len[(wr_cnt - 1) % 64] <= cur_len;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        prev_w <= write;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle, then idle with a sync-looking value
    // on rx_data while rx_valid is low (it must be ignored)
    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    int wb;
    int db;
    int n;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_adr",   {11'd0, adr},   32'd0);
        chk("rst_data",  {24'd0, data},  32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // good two-byte packet; sum 01+23+45+02+11+22 = 9E, CHK = 62
        wb = wr_cnt; db = done_cnt;
        send(8'hA5, 20); send(8'h01, 20); send(8'h23, 20); send(8'h45, 20);
        send(8'h02, 20); send(8'h11, 20); send(8'h22, 20); send(8'h62, 20);
        wait_idle("a_idle");
        chk("a_nwr",   wr_cnt - wb, 32'd2);
        chk("a_adr0",  {11'd0, log_adr[wb % 64]}, 32'h012345);
        chk("a_dat0",  {24'd0, log_data[wb % 64]}, 32'h11);
        chk("a_len0",  log_len[wb % 64], 32'd4);
        chk("a_adr1",  {11'd0, log_adr[(wb + 1) % 64]}, 32'h012346);
        chk("a_dat1",  {24'd0, log_data[(wb + 1) % 64]}, 32'h22);
        chk("a_len1",  log_len[(wb + 1) % 64], 32'd4);
        chk("a_done",  done_cnt - db, 32'd1);
        chk("a_error", {31'd0, error}, 32'd0);

        // same packet, bad checksum
        wb = wr_cnt; db = done_cnt;
        send(8'hA5, 20); send(8'h01, 20); send(8'h23, 20); send(8'h45, 20);
        send(8'h02, 20); send(8'h11, 20); send(8'h22, 20); send(8'h63, 20);
        wait_idle("b_idle");
        chk("b_nwr",   wr_cnt - wb, 32'd2);
        chk("b_done",  done_cnt - db, 32'd0);
        chk("b_error", {31'd0, error}, 32'd1);
        send(8'hA5, 2);
        chk("b_clr_error", {31'd0, error}, 32'd0);
        chk("b_busy",      {31'd0, busy},  32'd1);

        // bad high address bits, then garbage in IDLE
        wb = wr_cnt;
        send(8'h20, 2);
        chk("c_error", {31'd0, error}, 32'd1);
        chk("c_busy",  {31'd0, busy},  32'd0);
        send(8'h33, 2); send(8'h44, 2);
        chk("c_garb_error", {31'd0, error}, 32'd1);
        chk("c_garb_busy",  {31'd0, busy},  32'd0);
        chk("c_nwr",        wr_cnt - wb, 32'd0);

        // address wrap; sum 1F+FF+FF+02+AA+BB = 84, CHK = 7C
        wb = wr_cnt; db = done_cnt;
        send(8'hA5, 20); send(8'h1F, 20); send(8'hFF, 20); send(8'hFF, 20);
        send(8'h02, 20); send(8'hAA, 20); send(8'hBB, 20); send(8'h7C, 20);
        wait_idle("d_idle");
        chk("d_nwr",   wr_cnt - wb, 32'd2);
        chk("d_adr0",  {11'd0, log_adr[wb % 64]}, 32'h1FFFFF);
        chk("d_dat0",  {24'd0, log_data[wb % 64]}, 32'hAA);
        chk("d_adr1",  {11'd0, log_adr[(wb + 1) % 64]}, 32'h000000);
        chk("d_dat1",  {24'd0, log_data[(wb + 1) % 64]}, 32'hBB);
        chk("d_done",  done_cnt - db, 32'd1);
        chk("d_error", {31'd0, error}, 32'd0);

        // back-to-back DATA bytes: one written, one buffered, one overruns
        wb = wr_cnt; db = done_cnt;
        send(8'hA5, 20); send(8'h00, 20); send(8'h00, 20); send(8'h10, 20);
        send(8'h03, 20);
        @(negedge clk); rx_data = 8'h01; rx_valid = 1'b1;
        @(negedge clk); rx_data = 8'h02;
        @(negedge clk); rx_data = 8'h03;
        @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
        wait_idle("e_idle");
        chk("e_nwr",   wr_cnt - wb, 32'd2);
        chk("e_adr0",  {11'd0, log_adr[wb % 64]}, 32'h000010);
        chk("e_dat0",  {24'd0, log_data[wb % 64]}, 32'h01);
        chk("e_adr1",  {11'd0, log_adr[(wb + 1) % 64]}, 32'h000011);
        chk("e_dat1",  {24'd0, log_data[(wb + 1) % 64]}, 32'h02);
        chk("e_len1",  log_len[(wb + 1) % 64], 32'd4);
        chk("e_error", {31'd0, error}, 32'd1);
        chk("e_done",  done_cnt - db, 32'd0);

        // reset in the middle of a write pulse of a LEN=0 packet
        send(8'hA5, 20); send(8'h00, 20); send(8'h00, 20); send(8'h00, 20);
        send(8'h00, 20); send(8'h5A, 0);
        n = 0;
        while (write !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("f_pulse_seen", {31'd0, write}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("f_write", {31'd0, write}, 32'd0);
        chk("f_adr",   {11'd0, adr},   32'd0);
        chk("f_data",  {24'd0, data},  32'd0);
        chk("f_busy",  {31'd0, busy},  32'd0);
        chk("f_done",  {31'd0, done},  32'd0);
        chk("f_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // good packet after reset; sum 00+01+00+01+77 = 79, CHK = 87
        wb = wr_cnt; db = done_cnt;
        send(8'hA5, 20); send(8'h00, 20); send(8'h01, 20); send(8'h00, 20);
        send(8'h01, 20); send(8'h77, 20); send(8'h87, 20);
        wait_idle("g_idle");
        chk("g_nwr",   wr_cnt - wb, 32'd1);
        chk("g_adr0",  {11'd0, log_adr[wb % 64]}, 32'h000100);
        chk("g_dat0",  {24'd0, log_data[wb % 64]}, 32'h77);
        chk("g_len0",  log_len[wb % 64], 32'd4);
        chk("g_done",  done_cnt - db, 32'd1);
        chk("g_error", {31'd0, error}, 32'd0);

        chk("stable_during_pulse", stab_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
